// File: rtl/gf_2ton_digit_serial_multiplier.sv
// Digit-serial GF(2^n) multiplier, reflected bit order.
// Each BUSY cycle consumes NB_DIGIT bits of x, starting at x^0.
// The product is either reduced by POLY_R or left as the full carry-less product.
module gf_2ton_digit_serial_multiplier #(
    parameter int                 NB_DATA  = 128,
    parameter int                 NB_DIGIT = 8,
    parameter logic [NB_DATA-1:0] POLY_R   = {8'hE1, {(NB_DATA-8){1'b0}}}
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [NB_DATA-1:0]   i_data_x,
    input  logic [NB_DATA-1:0]   i_data_y,
    input  logic                 i_reduce,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_abort,
    output logic [2*NB_DATA-2:0] o_data_z,
    output logic                 o_valid,
    input  logic                 i_ready
);

    localparam int NB_PROD  = 2*NB_DATA-1;
    localparam int NB_STEPS = NB_DATA / NB_DIGIT;
    localparam int CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_STEPS-1);

    if (NB_DATA % NB_DIGIT != 0) begin : g_bad_digit
        $error("NB_DATA must be a multiple of NB_DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 accept;
    logic [CNT_W-1:0]     cnt_q;
    logic [NB_DATA-1:0]   x_q;
    logic [NB_PROD-1:0]   v_q;
    logic [NB_PROD-1:0]   z_q;
    logic                 red_q;
    logic [NB_PROD-1:0]   v_c;
    logic [NB_PROD-1:0]   z_c;

    // Multiply a reduced-field element by x: shift toward higher degree and
    // fold the x^NB_DATA term back in with the reflected reduction constant.
    function automatic logic [NB_DATA-1:0] mul_x(input logic [NB_DATA-1:0] v);
        mul_x = (v >> 1) ^ (v[0] ? POLY_R : '0);
    endfunction

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over accept, ready and the last digit.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && !i_abort) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_abort || i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One digit of shift-and-add: for each x bit, add the running y*x^k
    // term, then advance it by one power of x (reduced or plain shift).
    always_comb begin
        z_c = z_q;
        v_c = v_q;
        for (int i = 0; i < NB_DIGIT; i++) begin
            if (x_q[NB_DATA-1-i]) begin
                z_c = z_c ^ v_c;
            end
            if (red_q) begin
                v_c = {{(NB_DATA-1){1'b0}}, mul_x(v_c[NB_DATA-1:0])};
            end else begin
                v_c = v_c >> 1;
            end
        end
    end

    // Operand latch on accept, then one digit per BUSY cycle.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
            x_q   <= '0;
            v_q   <= '0;
            z_q   <= '0;
            red_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            x_q   <= i_data_x;
            // Reduced mode keeps y in the low NB_DATA bits; unreduced mode
            // aligns y so its x^0 coefficient sits at the product's top bit.
            v_q   <= i_reduce ? {{(NB_DATA-1){1'b0}}, i_data_y}
                              : {i_data_y, {(NB_DATA-1){1'b0}}};
            z_q   <= '0;
            red_q <= i_reduce;
        end else if (state_q == BUSY && !i_abort) begin
            cnt_q <= cnt_q + 1'b1;
            x_q   <= x_q << NB_DIGIT;
            v_q   <= v_c;
            z_q   <= z_c;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_data_z = (state_q == DONE) ? z_q : '0;

endmodule

// File: tb/tb_gf_2ton_digit_serial_multiplier.sv
// Bench for gf_2ton_digit_serial_multiplier: four instances (NB_DIGIT 1/8/32/128)
// share every input and are compared against a plain polynomial reference.
module tb_gf_2ton_digit_serial_multiplier;

    localparam int NB = 128;
    localparam int NP = 2*NB-1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] dx, dy;
    logic          red, vin, abt, rin;
    logic [NP-1:0] z  [4];
    logic          vo [4];
    logic          ro [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 32 : 128;
        gf_2ton_digit_serial_multiplier #(.NB_DATA(NB), .NB_DIGIT(D)) u_dut (
            .i_clock   (clk),
            .i_reset_n (rst_n),
            .i_data_x  (dx),
            .i_data_y  (dy),
            .i_reduce  (red),
            .i_valid   (vin),
            .o_ready   (ro[g]),
            .i_abort   (abt),
            .o_data_z  (z[g]),
            .o_valid   (vo[g]),
            .i_ready   (rin)
        );
    end

    function automatic int lat(input int g);
        case (g)
            0:       return NB / 1;
            1:       return NB / 8;
            2:       return NB / 32;
            default: return NB / 128;
        endcase
    endfunction

    function automatic bit all_rdy();
        return ro[0] && ro[1] && ro[2] && ro[3];
    endfunction

    function automatic logic [NB-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: convert to natural order, schoolbook carry-less multiply,
    // long-division by x^128+x^7+x^2+x+1, convert back to reflected order.
    function automatic logic [NP-1:0] model(input logic [NB-1:0] x, input logic [NB-1:0] y,
                                            input logic r);
        logic [NB-1:0] a, b;
        logic [NP-1:0] p, pm, res;
        for (int k = 0; k < NB; k++) begin
            a[k] = x[NB-1-k];
            b[k] = y[NB-1-k];
        end
        p = '0;
        for (int i = 0; i < NB; i++) begin
            if (a[i]) p = p ^ (NP'(b) << i);
        end
        res = '0;
        if (r) begin
            pm = '0;
            pm[128] = 1'b1; pm[7] = 1'b1; pm[2] = 1'b1; pm[1] = 1'b1; pm[0] = 1'b1;
            for (int d = NP-1; d >= NB; d--) begin
                if (p[d]) p = p ^ (pm << (d - NB));
            end
            for (int k = 0; k < NB; k++) res[NB-1-k] = p[k];
        end else begin
            for (int k = 0; k < NP; k++) res[NP-1-k] = p[k];
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request to all instances and follow each to completion.
    task automatic do_op(input logic [NB-1:0] x, input logic [NB-1:0] y, input logic r,
                         input logic [NP-1:0] exp, input int pct, input int hold,
                         input string tag);
        bit seen [4];
        bit done [4];
        bit fin;
        int k;
        k = 0;
        while (!all_rdy() && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready_in"}, NP'(all_rdy()), NP'(1));
        dx = x; dy = y; red = r; vin = 1'b1; rin = 1'b0; abt = 1'b0;
        @(posedge clk); #1;
        vin = 1'b0;
        dx  = rnd128();
        dy  = rnd128();
        red = 1'($urandom_range(1));
        for (int g = 0; g < 4; g++) begin
            seen[g] = 1'b0;
            done[g] = 1'b0;
        end
        fin = 1'b0;
        for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (!done[g]) begin
                    if (vo[g]) begin
                        if (!seen[g]) begin
                            chk($sformatf("%s_lat%0d", tag, g), NP'(cyc - 1), NP'(lat(g)));
                            seen[g] = 1'b1;
                        end
                        chk($sformatf("%s_z%0d", tag, g), z[g], exp);
                        chk($sformatf("%s_rdy_busy%0d", tag, g), NP'(ro[g]), NP'(0));
                    end else begin
                        chk($sformatf("%s_vhold%0d", tag, g), NP'(seen[g]), NP'(0));
                        chk($sformatf("%s_zzero%0d", tag, g), z[g], '0);
                    end
                end
            end
            rin = (cyc > hold) && ($urandom_range(99) < pct);
            fin = 1'b1;
            for (int g = 0; g < 4; g++) begin
                if (vo[g] && rin) done[g] = 1'b1;
                fin = fin && done[g];
            end
        end
        chk({tag, "_complete"}, NP'(fin), NP'(1));
        @(negedge clk);
        rin = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s_idle_rdy%0d", tag, g), NP'(ro[g]), NP'(1));
            chk($sformatf("%s_idle_vld%0d", tag, g), NP'(vo[g]), NP'(0));
        end
    endtask

    initial begin
        logic [NB-1:0] x, y;
        logic          r;
        logic [NP-1:0] e;

        rst_n = 1'b1; dx = '0; dy = '0; red = 1'b0; vin = 1'b0; abt = 1'b0; rin = 1'b0;
        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rst_rdy%0d", g), NP'(ro[g]), NP'(1));
            chk($sformatf("rst_vld%0d", g), NP'(vo[g]), NP'(0));
            chk($sformatf("rst_z%0d", g), z[g], '0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // x = 1 returns y in reduced mode.
        y = rnd128();
        do_op({1'b1, 127'b0}, y, 1'b1, NP'(y), 100, 0, "one_x");

        // Known GCM multiplication.
        do_op(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0388dace60b6a392f328c2b971b2fe78,
              1'b1, NP'(128'h5e2ec746917062882c85b0685353deb7), 100, 0, "gcm_vec");

        // Unreduced corner products.
        e = '0; e[NP-1] = 1'b1;
        do_op({1'b1, 127'b0}, {1'b1, 127'b0}, 1'b0, e, 100, 0, "unred_one");
        e = '0; e[0] = 1'b1;
        do_op(128'h1, 128'h1, 1'b0, e, 100, 0, "unred_top");

        // Result held with i_ready low for at least 10 DONE cycles.
        x = rnd128(); y = rnd128();
        do_op(x, y, 1'b1, model(x, y, 1'b1), 100, NB + 11, "hold");

        // Abort in IDLE with simultaneous i_valid: no accept.
        @(negedge clk);
        dx = rnd128(); dy = rnd128(); vin = 1'b1; abt = 1'b1;
        @(posedge clk); #1;
        vin = 1'b0; abt = 1'b0;
        @(negedge clk);
        chk("idle_abort_rdy", NP'(all_rdy()), NP'(1));
        chk("idle_abort_vld", NP'(vo[0] || vo[1] || vo[2] || vo[3]), NP'(0));

        // Abort at BUSY cycle 5.
        dx = rnd128(); dy = rnd128(); red = 1'b1; vin = 1'b1; rin = 1'b0;
        @(posedge clk); #1;
        vin = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("abort_busy_v0_c%0d", c), NP'(vo[0]), NP'(0));
            chk($sformatf("abort_busy_v1_c%0d", c), NP'(vo[1]), NP'(0));
        end
        abt = 1'b1;
        @(posedge clk); #1;
        abt = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("abort_after_v%0d", g), NP'(vo[g]), NP'(0));
                chk($sformatf("abort_after_r%0d", g), NP'(ro[g]), NP'(1));
            end
        end

        // Reset pulse during a second operation.
        dx = rnd128(); dy = rnd128(); red = 1'b0; vin = 1'b1;
        @(posedge clk); #1;
        vin = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("midrst_rdy%0d", g), NP'(ro[g]), NP'(1));
            chk($sformatf("midrst_vld%0d", g), NP'(vo[g]), NP'(0));
            chk($sformatf("midrst_z%0d", g), z[g], '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        x = rnd128(); y = rnd128();
        do_op(x, y, 1'b1, model(x, y, 1'b1), 100, 0, "post_rst");

        // Random regression with ready stalls, both modes.
        for (int n = 0; n < 14; n++) begin
            x = rnd128(); y = rnd128(); r = 1'(n % 2);
            do_op(x, y, r, model(x, y, r), 40, 0, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf_2ton_digit_serial_multiplier.md
GF_2TON_DIGIT_SERIAL_MULTIPLIER -- requirements
Module: gf_2toN_digit_serial_multiplier

Interface
REQ-001 SHALL have parameter NB_DATA, default 128: operand width in bits.
REQ-002 SHALL have parameter NB_DIGIT, default 8: x-operand bits consumed per cycle; NB_DATA mod NB_DIGIT must be 0. Elaboration SHALL fail otherwise.
REQ-003 SHALL have parameter POLY_R, default {8'hE1, 120'h0}: reduction constant in reflected order (GCM field x^128+x^7+x^2+x+1).
REQ-004 Ports:
  i_clock    in   1    clock; single clock domain, all flops on rising edge
  i_reset_n  in   1    reset; asynchronous assert, active-low
  i_data_x   in   NB_DATA       multiplier operand
  i_data_y   in   NB_DATA       multiplicand operand
  i_reduce   in   1    1: reduced NB_DATA-bit product; 0: full unreduced product
  i_valid    in   1    input request
  o_ready    out  1    block can accept a request
  i_abort    in   1    synchronous abort of the operation in flight
  o_data_z   out  2*NB_DATA-1   result
  o_valid    out  1    result valid
  i_ready    in   1    downstream accepts result

Function
REQ-005 Bit order SHALL be reflected: operand bit NB_DATA-1-k is the coefficient of x^k; unreduced output bit 2*NB_DATA-2-k is the coefficient of x^k.
REQ-006 FSM SHALL have states IDLE, BUSY, DONE; o_ready = 1 only in IDLE.
REQ-007 Accept SHALL occur on an edge where i_valid=1 and o_ready=1: operands and i_reduce are latched, digit counter cleared, IDLE->BUSY.
REQ-008 In BUSY, each cycle SHALL process exactly NB_DIGIT bits of latched x, starting at x^0 (bit NB_DATA-1) and ending at x^(NB_DATA-1); inputs are ignored while BUSY.
REQ-009 Counter SHALL count 0..NB_DATA/NB_DIGIT-1; on the edge where it equals NB_DATA/NB_DIGIT-1, BUSY->DONE and o_valid rises.
REQ-010 Latency SHALL be exactly NB_DATA/NB_DIGIT cycles from the accept edge to the first edge where o_valid=1 (16 for defaults), independent of operand values and mode.
REQ-011 Reduced mode SHALL produce x*y mod P in o_data_z[NB_DATA-1:0] with o_data_z[2*NB_DATA-2:NB_DATA] = 0.
REQ-012 Unreduced mode SHALL produce the full 2*NB_DATA-1 bit carry-less product x*y with no reduction.
REQ-013 In DONE, o_valid and o_data_z SHALL stay stable until an edge with i_ready=1; on that edge DONE->IDLE, o_valid falls.
REQ-014 Accept SHALL NOT occur in the DONE->IDLE cycle (o_ready is 0 in DONE); back-to-back throughput is one result per NB_DATA/NB_DIGIT+2 cycles minimum.
REQ-015 i_abort=1 in BUSY or DONE SHALL return to IDLE on the next edge, drop o_valid, and not produce a result; i_abort in IDLE SHALL be ignored and SHALL take priority over a simultaneous i_valid.
REQ-016 i_abort SHALL take priority over i_ready and over the last-digit transition.
REQ-017 o_data_z SHALL be zero whenever o_valid=0.

Reset
REQ-018 i_reset_n=0 SHALL immediately force IDLE, counter 0, o_valid=0, o_ready=1, o_data_z=0, internal accumulators 0, without needing a clock edge.
REQ-019 Reset mid-operation SHALL discard the operation; first accept after release SHALL yield correct result with normal latency.
REQ-020 Reset release SHALL be synchronised externally; block SHALL accept i_valid on the first edge after release.

Verification
REQ-021 Reduce, x=128'h8000..0 (=1), y=arbitrary -> o_data_z[127:0]=y, upper bits 0, o_valid at accept+16.
REQ-022 Reduce, x=66e94bd4ef8a2c3b884cfa59ca342b2e, y=0388dace60b6a392f328c2b971b2fe78 -> 5e2ec746917062882c85b0685353deb7.
REQ-023 Unreduce, x=y=128'h8000..0 -> o_data_z = 1 in bit 254 only; x=y=128'h0..01 (x^127) -> bit 0 only.
REQ-024 Hold i_ready=0 for 10 cycles in DONE -> o_valid and o_data_z stable throughout, o_ready=0; i_ready=1 -> IDLE next edge.
REQ-025 i_abort at BUSY cycle 5, then i_reset_n pulse low during a second operation -> no o_valid for either; next request returns correct result with latency 16.
REQ-026 Random regression, NB_DIGIT in {1,8,32,128}, both modes, random i_ready/i_valid stalls -> all results match bit-serial reference model.
